// File: rtl/rename_pkg.sv
// Shared types for the rename register file: default widths, ROB tag,
// rename-table entry and per-port read result.
package rename_pkg;

  localparam int unsigned XLEN_DEFAULT    = 32;
  localparam int unsigned ROB_LOG_DEFAULT = 4;

  typedef logic [ROB_LOG_DEFAULT-1:0] rob_tag_t;

  // One rename-table slot: busy flag plus producing ROB tag.
  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } rename_entry_t;

  // Resolved operand as seen by issue.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] value;
    logic                    ready;
    rob_tag_t                tag;
  } rd_result_t;

endpackage

// File: rtl/rf_read_port.sv
// Combinational operand resolver for a single read port: zero register,
// architectural value, same-cycle commit bypass, or wait on a ROB tag.
module rf_read_port
  import rename_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned ROB_LOG = ROB_LOG_DEFAULT,
  parameter int unsigned AW      = 5
) (
  input  logic               valid,
  input  logic [AW-1:0]      addr,
  input  logic [XLEN-1:0]    reg_value,
  input  logic               busy,
  input  logic [ROB_LOG-1:0] tag,
  input  logic               commit_valid,
  input  logic [ROB_LOG-1:0] commit_tag,
  input  logic [XLEN-1:0]    commit_value,
  output logic [XLEN-1:0]    value,
  output logic               ready,
  output logic [ROB_LOG-1:0] wait_tag
);

  // Priority resolution; an idle port drives all zeros.
  always_comb begin
    value    = '0;
    ready    = 1'b0;
    wait_tag = '0;
    if (valid) begin
      if (addr == '0) begin
        ready = 1'b1;
      end else if (!busy) begin
        value = reg_value;
        ready = 1'b1;
      end else if (commit_valid && (commit_tag == tag)) begin
        value = commit_value;
        ready = 1'b1;
      end else begin
        wait_tag = tag;
      end
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename table (busy + ROB tag).
// Optional checkpoint support is enabled by defining RENAME_CKPT_EN, which adds
// ckpt_save/ckpt_restore and a shadow copy of the rename table.
module rename_regfile
  import rename_pkg::*;
#(
  parameter  int unsigned XLEN    = XLEN_DEFAULT,
  parameter  int unsigned NREG    = 32,
  parameter  int unsigned ROB_LOG = ROB_LOG_DEFAULT,
  parameter  int unsigned NRD     = 2,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [NRD-1:0]         rd_valid,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*XLEN-1:0]    rd_value,
  output logic [NRD-1:0]         rd_ready,
  output logic [NRD*ROB_LOG-1:0] rd_tag,
  input  logic                   commit_valid,
  input  logic [AW-1:0]          commit_dest,
  input  logic [XLEN-1:0]        commit_value,
  input  logic [ROB_LOG-1:0]     commit_tag,
  input  logic                   rename_valid,
  input  logic [AW-1:0]          rename_rd,
  input  logic [ROB_LOG-1:0]     rename_tag,
`ifdef RENAME_CKPT_EN
  input  logic                   ckpt_save,
  input  logic                   ckpt_restore,
`endif
  input  logic                   flush,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_value
);

  logic [XLEN-1:0]    regs     [NREG];
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;
  logic [ROB_LOG-1:0] tag      [NREG];
  logic [ROB_LOG-1:0] tag_nxt  [NREG];
  logic               commit_match;
  logic               rename_hit;

  assign commit_match = commit_valid && busy[commit_dest] && (tag[commit_dest] == commit_tag);
  assign rename_hit   = rename_valid && (rename_rd != '0);

`ifdef RENAME_CKPT_EN
  logic [NREG-1:0]    sh_busy;
  logic [NREG-1:0]    sh_busy_nxt;
  logic [ROB_LOG-1:0] sh_tag     [NREG];
  logic [ROB_LOG-1:0] sh_tag_nxt [NREG];
`endif

  // Next rename table: flush, then restore, then commit-clear followed by rename.
  always_comb begin
    busy_nxt = busy;
    tag_nxt  = tag;
`ifdef RENAME_CKPT_EN
    sh_busy_nxt = sh_busy;
    sh_tag_nxt  = sh_tag;
    if (commit_valid && sh_busy[commit_dest] && (sh_tag[commit_dest] == commit_tag)) begin
      sh_busy_nxt[commit_dest] = 1'b0;
    end
`endif
    if (flush) begin
      busy_nxt = '0;
`ifdef RENAME_CKPT_EN
    end else if (ckpt_restore) begin
      busy_nxt = sh_busy_nxt;
      tag_nxt  = sh_tag_nxt;
`endif
    end else begin
      if (commit_match) begin
        busy_nxt[commit_dest] = 1'b0;
      end
      // Rename is applied after commit so it wins on the same register.
      if (rename_hit) begin
        busy_nxt[rename_rd] = 1'b1;
        tag_nxt[rename_rd]  = rename_tag;
      end
`ifdef RENAME_CKPT_EN
      if (ckpt_save) begin
        sh_busy_nxt = busy_nxt;
        sh_tag_nxt  = tag_nxt;
      end
`endif
    end
  end

  // State update; register 0 is never written and its busy bit never sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
`ifdef RENAME_CKPT_EN
      sh_busy <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        sh_tag[i] <= '0;
      end
`endif
    end else if (rdy) begin
      if (commit_valid && (commit_dest != '0)) begin
        regs[commit_dest] <= commit_value;
      end
      busy <= busy_nxt;
      tag  <= tag_nxt;
`ifdef RENAME_CKPT_EN
      sh_busy <= sh_busy_nxt;
      sh_tag  <= sh_tag_nxt;
`endif
    end
  end

  // One combinational resolver per operand port.
  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    rf_read_port #(
      .XLEN    (XLEN),
      .ROB_LOG (ROB_LOG),
      .AW      (AW)
    ) u_port (
      .valid        (rd_valid[p]),
      .addr         (addr),
      .reg_value    (regs[addr]),
      .busy         (busy[addr]),
      .tag          (tag[addr]),
      .commit_valid (commit_valid),
      .commit_tag   (commit_tag),
      .commit_value (commit_value),
      .value        (rd_value[p*XLEN +: XLEN]),
      .ready        (rd_ready[p]),
      .wait_tag     (rd_tag[p*ROB_LOG +: ROB_LOG])
    );
  end

  assign dbg_value = regs[dbg_addr];

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed vector table, randomized run against a
// behavioural model, a mid-run reset, and the checkpoint sequence when enabled.
module tb_rename_regfile;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned ROB_LOG = 4;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, rdy, flush;
  logic [NRD-1:0]         rd_valid;
  logic [NRD*AW-1:0]      rd_addr;
  logic [NRD*XLEN-1:0]    rd_value;
  logic [NRD-1:0]         rd_ready;
  logic [NRD*ROB_LOG-1:0] rd_tag;
  logic                   commit_valid;
  logic [AW-1:0]          commit_dest;
  logic [XLEN-1:0]        commit_value;
  logic [ROB_LOG-1:0]     commit_tag;
  logic                   rename_valid;
  logic [AW-1:0]          rename_rd;
  logic [ROB_LOG-1:0]     rename_tag;
  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_value;
`ifdef RENAME_CKPT_EN
  logic                   ckpt_save, ckpt_restore;
`endif

  rename_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_value     (rd_value),
    .rd_ready     (rd_ready),
    .rd_tag       (rd_tag),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .rename_valid (rename_valid),
    .rename_rd    (rename_rd),
    .rename_tag   (rename_tag),
`ifdef RENAME_CKPT_EN
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
`endif
    .flush        (flush),
    .dbg_addr     (dbg_addr),
    .dbg_value    (dbg_value)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: value array plus a busy/tag entry per register.
  logic [XLEN-1:0]    m_regs [NREG];
  logic               m_busy [NREG];
  logic [ROB_LOG-1:0] m_tag  [NREG];

  typedef struct {
    logic rdy; logic flush; logic [1:0] rv; logic [AW-1:0] a0; logic [AW-1:0] a1;
    logic cv; logic [AW-1:0] cd; logic [ROB_LOG-1:0] ct; logic [XLEN-1:0] cval;
    logic rnv; logic [AW-1:0] rnd; logic [ROB_LOG-1:0] rnt; logic [AW-1:0] dbg;
    logic r0; logic [XLEN-1:0] v0; logic [ROB_LOG-1:0] t0;
    logic r1; logic [XLEN-1:0] v1; logic [ROB_LOG-1:0] t1;
    logic [XLEN-1:0] dv;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  // Applies the update rules to the model using the inputs held this cycle.
  task automatic model_step();
    int cd, rnd;
    cd  = int'(commit_dest);
    rnd = int'(rename_rd);
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (commit_valid && cd != 0) m_regs[cd] = commit_value;
      if (flush) begin
        for (int i = 0; i < int'(NREG); i++) m_busy[i] = 1'b0;
      end else begin
        if (commit_valid && m_busy[cd] && m_tag[cd] == commit_tag) m_busy[cd] = 1'b0;
        if (rename_valid && rnd != 0) begin
          m_busy[rnd] = 1'b1;
          m_tag[rnd]  = rename_tag;
        end
      end
    end
  endtask

  // Expected result of one read port from the model and current inputs.
  task automatic model_read(input int p, output logic [XLEN-1:0] v, output logic r,
                            output logic [ROB_LOG-1:0] t);
    int a;
    a = int'(rd_addr[p*AW +: AW]);
    v = '0; r = 1'b0; t = '0;
    if (!rd_valid[p]) return;
    if (a == 0) r = 1'b1;
    else if (!m_busy[a]) begin v = m_regs[a]; r = 1'b1; end
    else if (commit_valid && commit_tag == m_tag[a]) begin v = commit_value; r = 1'b1; end
    else t = m_tag[a];
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; flush = 1'b0; rd_valid = '0; rd_addr = '0;
    commit_valid = 1'b0; commit_dest = '0; commit_value = '0; commit_tag = '0;
    rename_valid = 1'b0; rename_rd = '0; rename_tag = '0; dbg_addr = '0;
`ifdef RENAME_CKPT_EN
    ckpt_save = 1'b0; ckpt_restore = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_port(input string name, input int idx, input int p,
                          input logic r, input logic [XLEN-1:0] v, input logic [ROB_LOG-1:0] t);
    chk({name, "_ready"}, idx, XLEN'(rd_ready[p]), XLEN'(r));
    chk({name, "_value"}, idx, rd_value[p*XLEN +: XLEN], v);
    chk({name, "_tag"}, idx, XLEN'(rd_tag[p*ROB_LOG +: ROB_LOG]), XLEN'(t));
  endtask

  task automatic chk_model(input string name, input int idx);
    logic [XLEN-1:0] v; logic r; logic [ROB_LOG-1:0] t;
    for (int p = 0; p < int'(NRD); p++) begin
      model_read(p, v, r, t);
      chk_port(name, idx * 2 + p, p, r, v, t);
    end
    chk({name, "_dbg"}, idx, dbg_value, m_regs[int'(dbg_addr)]);
  endtask

  vec_t vt[$];

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    step(); step();
    rst = 1'b0;

    //      rdy fl  rv    a0 a1 cv cd ct cval          rnv rnd rnt dbg r0 v0            t0 r1 v1            t1 dv
    vt.push_back('{1,0,2'b11, 5, 5, 0, 0,0,32'h0,        0, 0,0, 5, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 5, 5, 0, 0,0,32'h0,        1, 5,3, 0, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 5, 0, 0, 0,0,32'h0,        0, 0,0, 5, 0,32'h0,        3, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 5, 5, 1, 5,3,32'hDEADBEEF, 0, 0,0, 5, 1,32'hDEADBEEF, 0, 1,32'hDEADBEEF, 0, 32'h0});
    vt.push_back('{1,0,2'b11, 5, 7, 0, 0,0,32'h0,        0, 0,0, 5, 1,32'hDEADBEEF, 0, 1,32'h0,        0, 32'hDEADBEEF});
    vt.push_back('{1,0,2'b11, 7, 7, 0, 0,0,32'h0,        1, 7,2, 7, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 7, 7, 0, 0,0,32'h0,        1, 7,5, 7, 0,32'h0,        2, 0,32'h0,        2, 32'h0});
    vt.push_back('{1,0,2'b11, 7, 7, 1, 7,2,32'h11,       0, 0,0, 7, 0,32'h0,        5, 0,32'h0,        5, 32'h0});
    vt.push_back('{1,0,2'b11, 7, 0, 0, 0,0,32'h0,        0, 0,0, 7, 0,32'h0,        5, 1,32'h0,        0, 32'h11});
    vt.push_back('{1,0,2'b11, 9, 9, 1, 9,4,32'h99,       1, 9,6, 9, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 9, 9, 0, 0,0,32'h0,        0, 0,0, 9, 0,32'h0,        6, 0,32'h0,        6, 32'h99});
    vt.push_back('{1,0,2'b11, 1, 2, 0, 0,0,32'h0,        1, 1,1, 0, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 1, 2, 0, 0,0,32'h0,        1, 2,2, 0, 0,32'h0,        1, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 2, 3, 0, 0,0,32'h0,        1, 3,3, 0, 0,32'h0,        2, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 3, 4, 0, 0,0,32'h0,        1, 4,4, 0, 0,32'h0,        3, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,1,2'b11, 4,10, 0, 0,0,32'h0,        1,10,7, 0, 0,32'h0,        4, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 1,10, 0, 0,0,32'h0,        0, 0,0, 0, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11, 4, 9, 0, 0,0,32'h0,        0, 0,0, 9, 1,32'h0,        0, 1,32'h99,       0, 32'h99});
    vt.push_back('{0,0,2'b11,11,12, 1,12,0,32'h55,       1,11,1,12, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b11,11,12, 0, 0,0,32'h0,        0, 0,0,12, 1,32'h0,        0, 1,32'h0,        0, 32'h0});
    vt.push_back('{1,0,2'b10, 5, 5, 0, 0,0,32'h0,        1, 5,9, 5, 0,32'h0,        0, 1,32'hDEADBEEF, 0, 32'hDEADBEEF});
    vt.push_back('{1,0,2'b01, 5, 5, 0, 0,0,32'h0,        0, 0,0, 5, 0,32'h0,        9, 0,32'h0,        0, 32'hDEADBEEF});
    vt.push_back('{1,0,2'b11, 0, 5, 1, 0,9,32'h77,       1, 0,3, 0, 1,32'h0,        0, 1,32'h77,       0, 32'h0});
    vt.push_back('{1,0,2'b11, 0, 5, 0, 0,0,32'h0,        0, 0,0, 0, 1,32'h0,        0, 0,32'h0,        9, 32'h0});

    foreach (vt[i]) begin
      rdy = vt[i].rdy; flush = vt[i].flush; rd_valid = vt[i].rv;
      rd_addr = {vt[i].a1, vt[i].a0};
      commit_valid = vt[i].cv; commit_dest = vt[i].cd; commit_tag = vt[i].ct;
      commit_value = vt[i].cval;
      rename_valid = vt[i].rnv; rename_rd = vt[i].rnd; rename_tag = vt[i].rnt;
      dbg_addr = vt[i].dbg;
      #1;
      chk_port("vec_p0", i, 0, vt[i].r0, vt[i].v0, vt[i].t0);
      chk_port("vec_p1", i, 1, vt[i].r1, vt[i].v1, vt[i].t1);
      chk("vec_dbg", i, dbg_value, vt[i].dv);
      step();
    end

    // Randomized traffic; commit tags often chosen to hit the current rename tag.
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(9) != 0);
      flush = ($urandom_range(24) == 0);
      rd_valid = NRD'($urandom_range(3));
      rd_addr = (NRD*AW)'($urandom);
      commit_valid = $urandom_range(1) == 1;
      commit_dest = AW'($urandom_range(NREG - 1));
      commit_value = $urandom;
      commit_tag = ($urandom_range(1) == 1) ? m_tag[int'(commit_dest)] : ROB_LOG'($urandom);
      rename_valid = $urandom_range(1) == 1;
      rename_rd = AW'($urandom_range(NREG - 1));
      rename_tag = ROB_LOG'($urandom);
      dbg_addr = AW'($urandom_range(NREG - 1));
      #1;
      chk_model("rand", n);
      step();
    end

    // Reset mid-run with a rename pending clears the whole table and array.
    idle_inputs();
    rename_valid = 1'b1; rename_rd = 5'd6; rename_tag = 4'd3;
    commit_valid = 1'b1; commit_dest = 5'd6; commit_value = 32'hABCD;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    rd_valid = 2'b11; rd_addr = {5'd6, 5'd9}; dbg_addr = 5'd9;
    #1;
    chk_port("rst_p0", 0, 0, 1'b1, 32'h0, 4'd0);
    chk_port("rst_p1", 0, 1, 1'b1, 32'h0, 4'd0);
    chk("rst_dbg", 0, dbg_value, 32'h0);
    step();

`ifdef RENAME_CKPT_EN
    // Checkpoint: snapshot older rename, commit it, restore -> register ready.
    idle_inputs();
    flush = 1'b1; step();
    idle_inputs();
    rename_valid = 1'b1; rename_rd = 5'd3; rename_tag = 4'd1; step();
    idle_inputs();
    ckpt_save = 1'b1; step();
    idle_inputs();
    rename_valid = 1'b1; rename_rd = 5'd3; rename_tag = 4'd2; step();
    idle_inputs();
    rd_valid = 2'b01; rd_addr = {5'd0, 5'd3};
    commit_valid = 1'b1; commit_dest = 5'd3; commit_tag = 4'd1; commit_value = 32'h33;
    #1;
    chk_port("ckpt_pre", 0, 0, 1'b0, 32'h0, 4'd2);
    step();
    idle_inputs();
    ckpt_restore = 1'b1; step();
    idle_inputs();
    rd_valid = 2'b01; rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
    #1;
    chk_port("ckpt_post", 0, 0, 1'b1, 32'h33, 4'd0);
    chk("ckpt_dbg", 0, dbg_value, 32'h33);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
Parametrised architectural register file with a per-register rename table: a busy bit plus a ROB tag for each register.
- Serves NRD operand-read ports to issue, so dual-issue needs 4.
- Takes one commit and one rename per cycle, and is flushed on mispredict.
- Sits between decode/issue and the ROB commit stage.
- Busy is an explicit bit, so ROB tag 0 is a legal tag.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers; register 0 is hardwired to zero
ROB_LOG, 4, ROB tag width
NRD, 2, number of operand read ports
AW, $clog2(NREG), register address width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state holds
rd_valid  in  NRD  per-port read request
rd_addr  in  NRD*AW  per-port source register
rd_value  out  NRD*XLEN  operand value (valid when rd_ready=1)
rd_ready  out  NRD  1 = value available, 0 = wait on rd_tag
rd_tag  out  NRD*ROB_LOG  producing ROB tag (valid when rd_ready=0)
commit_valid  in  1  ROB commit strobe
commit_dest  in  AW  committed destination register
commit_value  in  XLEN  committed result
commit_tag  in  ROB_LOG  ROB tag of the committing entry
rename_valid  in  1  issue allocates a destination
rename_rd  in  AW  renamed register
rename_tag  in  ROB_LOG  newly allocated ROB tag
flush  in  1  mispredict: clear all busy bits
dbg_addr  in  AW  debug read address
dbg_value  out  XLEN  regs[dbg_addr], combinational

Behaviour:
- Reset is synchronous, with rst, clk as already decided.
  - On rst: all regs = 0, all busy = 0, all tags = 0.
  - Read outputs are combinational from state.
  - rd_valid=0 forces that port's rd_value=0, rd_ready=0, rd_tag=0.
- Read resolution, per port, combinational, evaluated in priority order:
  - addr==0 -> value 0, ready 1.
  - !busy -> regs[addr], ready 1.
  - commit_valid && commit_tag==tag[addr] -> commit_value, ready 1 (bypass).
  - Otherwise -> ready 0, rd_tag = tag[addr], rd_value = 0.
- A read never sees a rename issued in the same cycle. Intra-group dependencies are the issue stage's job.
- Sequential update, when rdy=1 and rst=0, in priority order:
  - flush: all busy <= 0; regs are still written by a same-cycle commit; a same-cycle rename is dropped.
  - Otherwise, commit and then rename are applied:
    - Commit with dest!=0: regs[dest] <= value.
    - Commit with busy[dest] && tag[dest]==commit_tag: busy[dest] <= 0.
    - Rename with rd!=0: busy[rd] <= 1, tag[rd] <= rename_tag.
  - If commit and rename hit the same register, the rename wins: busy stays 1 with the new tag.
- Writes to register 0 are ignored and its busy bit never sets.
- rdy=0: no state changes; reads remain combinational.
- Latency: a committed value is visible via bypass in the same cycle and from the array on the next cycle.

Optional Feature:
RENAME_CKPT_EN
- Defined: adds inputs ckpt_save (1) and ckpt_restore (1), plus one shadow busy/tag table.
  - ckpt_save copies the post-update rename table into the shadow.
  - Every commit also clears the shadow busy bit for dest when the shadow tag matches commit_tag.
  - ckpt_restore loads busy/tag from the shadow (after that cycle's commit clearing); regs are untouched.
  - Priority: flush > restore > save/normal.
- Undefined: the ports and shadow are absent; only a full flush exists.

Decomposition:
- Package rename_pkg holds: ROB_LOG default, rob_tag_t, the rename-entry struct {busy, tag}, and the read-result struct {value, ready, tag}.
- One sub-module is natural: rf_read_port, the combinational resolver for one port, instantiated NRD times.

Test Plan:
- Reset, then read x5 on both ports -> value 0, ready 1 on both.
- Rename x5 to tag 3, next cycle read x5 -> ready 0, tag 3. Then commit tag 3 to x5 with value 0xDEADBEEF while reading x5 -> same-cycle ready 1, value 0xDEADBEEF; next cycle busy is clear and the array reads 0xDEADBEEF.
- Same register, two renames, one stale commit:
  - Rename x7 to tag 2, then rename x7 to tag 5, then commit tag 2 to x7 with value 0x11.
  - Required: regs[7]=0x11, busy stays 1, rd_tag=5.
- Commit and rename to x9 in the same cycle (commit tag 4, rename tag 6) -> x9 busy with tag 6, value updated.
- Rename x1..x4, then flush with a simultaneous rename of x10 -> all ready 1 next cycle; x10 not busy.
- (RENAME_CKPT_EN) Rename x3 to tag 1, save, rename x3 to tag 2, commit tag 1, restore -> x3 ready 1 with the committed value.
